// File: rtl/uart_serial_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_serial_bridge
// Description : 8N1 UART bit-level adapter. Deserializes txd into a FIFO-backed
//               byte stream and serializes an input byte stream onto rxd.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_serial_bridge #(
    parameter int DIV        = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       txd,
    output logic       rxd,
    output logic       serial_out_valid,
    input  logic       serial_out_ready,
    output logic [7:0] serial_out_bits,
    input  logic       serial_in_valid,
    output logic       serial_in_ready,
    input  logic [7:0] serial_in_bits,
    output logic       framing_error,
    output logic       overflow
);

    localparam int          c_AW      = $clog2(FIFO_DEPTH);
    localparam int          c_PW      = c_AW + 1;
    localparam logic [15:0] c_DIV_M1  = 16'(DIV - 1);
    localparam logic [15:0] c_HALF_M1 = 16'(DIV / 2 - 1);

    localparam logic [1:0] c_RX_IDLE  = 2'd0;
    localparam logic [1:0] c_RX_START = 2'd1;
    localparam logic [1:0] c_RX_DATA  = 2'd2;
    localparam logic [1:0] c_RX_STOP  = 2'd3;

    localparam logic c_TX_IDLE  = 1'b0;
    localparam logic c_TX_SHIFT = 1'b1;

    // ------------------------------------------------------------------
    // txd synchronizer
    // ------------------------------------------------------------------
    logic r_txd_meta;
    logic r_txd_s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_txd_meta <= 1'b1;
            r_txd_s    <= 1'b1;
        end else begin
            r_txd_meta <= txd;
            r_txd_s    <= r_txd_meta;
        end
    end

    // ------------------------------------------------------------------
    // RX deserializer
    // ------------------------------------------------------------------
    logic [1:0]  r_rx_state;
    logic [15:0] r_rx_cnt;
    logic [2:0]  r_rx_idx;
    logic [7:0]  r_rx_shift;
    logic        r_rx_armed;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic            r_framing_error;
    logic            r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_stop_sample;
    logic w_push;

    assign w_empty       = (r_wr_ptr == r_rd_ptr);
    assign w_full        = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                           (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop         = !w_empty && serial_out_ready;
    assign w_stop_sample = (r_rx_state == c_RX_STOP) && (r_rx_cnt == 16'd0);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_push        = w_stop_sample && r_txd_s && (!w_full || w_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_state <= c_RX_IDLE;
            r_rx_cnt   <= 16'd0;
            r_rx_idx   <= 3'd0;
            r_rx_shift <= 8'd0;
            r_rx_armed <= 1'b1;
        end else begin
            case (r_rx_state)
                c_RX_IDLE: begin
                    // A line held low after a bad stop bit must go high first.
                    if (r_txd_s) begin
                        r_rx_armed <= 1'b1;
                    end else if (r_rx_armed) begin
                        r_rx_state <= c_RX_START;
                        r_rx_cnt   <= c_HALF_M1;
                    end
                end
                c_RX_START: begin
                    if (r_rx_cnt == 16'd0) begin
                        if (!r_txd_s) begin
                            r_rx_state <= c_RX_DATA;
                            r_rx_cnt   <= c_DIV_M1;
                            r_rx_idx   <= 3'd0;
                        end else begin
                            r_rx_state <= c_RX_IDLE;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 16'd1;
                    end
                end
                c_RX_DATA: begin
                    if (r_rx_cnt == 16'd0) begin
                        r_rx_shift <= {r_txd_s, r_rx_shift[7:1]};
                        r_rx_cnt   <= c_DIV_M1;
                        r_rx_idx   <= r_rx_idx + 3'd1;
                        if (r_rx_idx == 3'd7) begin
                            r_rx_state <= c_RX_STOP;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 16'd1;
                    end
                end
                default: begin
                    if (r_rx_cnt == 16'd0) begin
                        r_rx_state <= c_RX_IDLE;
                        r_rx_armed <= r_txd_s;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO and sticky status
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_framing_error <= 1'b0;
            r_overflow      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'd0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= r_rx_shift;
                r_wr_ptr                  <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            if (w_stop_sample && !r_txd_s) begin
                r_framing_error <= 1'b1;
            end
            if (w_stop_sample && r_txd_s && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign serial_out_valid = !w_empty;
    assign serial_out_bits  = r_mem[r_rd_ptr[c_AW-1:0]];
    assign framing_error    = r_framing_error;
    assign overflow         = r_overflow;

    // ------------------------------------------------------------------
    // TX serializer
    // ------------------------------------------------------------------
    logic        r_tx_state;
    logic [15:0] r_tx_cnt;
    logic [3:0]  r_tx_bit;
    logic [8:0]  r_tx_shift;
    logic        r_rxd;
    logic        r_in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_state <= c_TX_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_bit   <= 4'd0;
            r_tx_shift <= 9'd0;
            r_rxd      <= 1'b1;
            r_in_ready <= 1'b0;
        end else begin
            case (r_tx_state)
                c_TX_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (serial_in_valid && r_in_ready) begin
                        r_tx_state <= c_TX_SHIFT;
                        r_in_ready <= 1'b0;
                        r_rxd      <= 1'b0;
                        r_tx_shift <= {1'b1, serial_in_bits};
                        r_tx_cnt   <= c_DIV_M1;
                        r_tx_bit   <= 4'd0;
                    end
                end
                default: begin
                    // Leave one cycle early so the idle handshake cycle is the
                    // stop bit's last cycle and frames stay gapless.
                    if (r_tx_bit == 4'd9 && r_tx_cnt == 16'd1) begin
                        r_tx_state <= c_TX_IDLE;
                        r_in_ready <= 1'b1;
                    end else if (r_tx_cnt == 16'd0) begin
                        r_tx_cnt   <= c_DIV_M1;
                        r_tx_bit   <= r_tx_bit + 4'd1;
                        r_rxd      <= r_tx_shift[0];
                        r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                    end else begin
                        r_tx_cnt <= r_tx_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    assign rxd             = r_rxd;
    assign serial_in_ready = r_in_ready;

endmodule
`default_nettype wire
